hazard_stall_unit: RTL

Pipeline hazard and stall controller for the 5-stage RV32I core: the producer-side counterpart to forwarding control, deciding when the pipeline cannot be covered by a forwarding path and must stall, bubble, or squash. Sits beside the pipeline registers. Drives their load/bubble enables and the PC load from decoded control words, cache handshakes and ID-stage redirects. Holds a redirect latched across an outstanding I-cache miss and keeps stall/flush performance counters.

---
 rtl/hazard_stall_unit.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/hazard_stall_unit.sv
// Hazard and stall controller for the 5-stage RV32I pipeline.
// Also holds a redirect across an I-miss and keeps stall/flush counters.
package rv32i_pkg;
   typedef enum logic [6:0] {
      op_lui   = 7'b0110111,
      op_auipc = 7'b0010111,
      op_jal   = 7'b1101111,
      op_jalr  = 7'b1100111,
      op_br    = 7'b1100011,
      op_load  = 7'b0000011,
      op_store = 7'b0100011,
      op_imm   = 7'b0010011,
      op_reg   = 7'b0110011,
      op_csr   = 7'b1110011
   } rv32i_opcode;

   typedef enum logic [2:0] {
      alu_out  = 3'd0,
      br_en    = 3'd1,
      u_imm    = 3'd2,
      lw       = 3'd3,
      pc_plus4 = 3'd4
   } regfilemux_sel_t;

   typedef struct packed {
      rv32i_opcode     opcode;
      logic [2:0]      funct3;
      logic [4:0]      rs1_id;
      logic [4:0]      rs2_id;
      logic [4:0]      rd_id;
      logic            load_regfile;
      regfilemux_sel_t regfile_mux_sel;
   } rv32i_control_word;
endpackage

module hazard_stall_unit
   import rv32i_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  rv32i_control_word id_ex_in_ctrl,
   input  rv32i_control_word id_ex_out_ctrl,
   input  rv32i_control_word ex_mem_out_ctrl,
   input  logic              icache_resp,
   input  logic              dcache_resp,
   input  logic              id_redirect,
   input  logic [31:0]       id_redirect_target,
   output logic              pc_load,
   output logic              if_id_load,
   output logic              id_ex_load,
   output logic              ex_mem_load,
   output logic              mem_wb_load,
   output logic              if_id_bubble,
   output logic              id_ex_bubble,
   output logic              pc_redirect_valid,
   output logic [31:0]       pc_redirect_target,
   output logic [31:0]       stall_cycles,
   output logic [31:0]       flush_count
);

   typedef enum logic {RUN, KILL} state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] kill_target;

   logic uses_rs1;
   logic uses_rs2;
   logic ex_match;
   logic mem_match;
   logic early_use;
   logic mem_access;
   logic dstall;
   logic lustall;

   function automatic logic hits(
      input rv32i_control_word p,
      input rv32i_control_word d,
      input logic              u1,
      input logic              u2
   );
      logic wr;
      wr = p.load_regfile && (p.rd_id != 5'd0);
      return wr && ((u1 && p.rd_id == d.rs1_id) ||
                    (u2 && p.rd_id == d.rs2_id));
   endfunction

   logic unused_ok;
   assign unused_ok = &{1'b0, id_ex_in_ctrl.rd_id,
                        id_ex_in_ctrl.load_regfile,
                        id_ex_in_ctrl.regfile_mux_sel,
                        id_ex_out_ctrl.funct3,
                        id_ex_out_ctrl.rs1_id,
                        id_ex_out_ctrl.rs2_id,
                        ex_mem_out_ctrl.funct3,
                        ex_mem_out_ctrl.rs1_id,
                        ex_mem_out_ctrl.rs2_id,
                        ex_mem_out_ctrl.regfile_mux_sel};

   always_comb begin : hazard_detect
      uses_rs1 = !(id_ex_in_ctrl.opcode inside
                   {op_lui, op_auipc, op_jal});
      uses_rs2 = id_ex_in_ctrl.opcode inside
                 {op_br, op_store, op_reg};
      ex_match  = hits(id_ex_out_ctrl, id_ex_in_ctrl,
                       uses_rs1, uses_rs2);
      mem_match = hits(ex_mem_out_ctrl, id_ex_in_ctrl,
                       uses_rs1, uses_rs2);
      // Branch compares and set-less-than resolve in ID, so they
      // need the value one stage earlier than ordinary ALU users.
      early_use = (id_ex_in_ctrl.opcode inside {op_br, op_jalr}) ||
                  ((id_ex_in_ctrl.opcode inside {op_reg, op_imm}) &&
                   (id_ex_in_ctrl.funct3 inside {3'd2, 3'd3}));
      mem_access = ex_mem_out_ctrl.opcode inside {op_load, op_store};
      dstall = mem_access && !dcache_resp;
      lustall = ((id_ex_out_ctrl.opcode == op_load) && ex_match) ||
                (early_use &&
                 ((ex_match &&
                   (id_ex_out_ctrl.opcode != op_lui) &&
                   (id_ex_out_ctrl.regfile_mux_sel != br_en)) ||
                  ((ex_mem_out_ctrl.opcode == op_load) && mem_match)));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= RUN;
         kill_target  <= 32'd0;
         stall_cycles <= 32'd0;
         flush_count  <= 32'd0;
      end else begin
         state <= state_next;
         if (state == RUN && state_next == KILL)
            kill_target <= id_redirect_target;
         stall_cycles <= stall_cycles + {31'd0, !pc_load};
         flush_count  <= flush_count + {31'd0, pc_redirect_valid};
      end
   end

   always_comb begin : next_state
      state_next = state;
      if (!dstall) begin
         case (state)
            RUN:  if (!lustall && id_redirect && !icache_resp)
                     state_next = KILL;
            KILL: if (icache_resp)
                     state_next = RUN;
            default: state_next = RUN;
         endcase
      end
   end

   always_comb begin : outputs
      pc_load            = 1'b1;
      if_id_load         = 1'b1;
      id_ex_load         = 1'b1;
      ex_mem_load        = 1'b1;
      mem_wb_load        = 1'b1;
      if_id_bubble       = 1'b0;
      id_ex_bubble       = 1'b0;
      pc_redirect_valid  = 1'b0;
      pc_redirect_target = (state == KILL) ? kill_target
                                           : id_redirect_target;
      if (!rst) begin
         pc_load            = 1'b0;
         if_id_load         = 1'b0;
         id_ex_load         = 1'b0;
         ex_mem_load        = 1'b0;
         mem_wb_load        = 1'b0;
         if_id_bubble       = 1'b1;
         id_ex_bubble       = 1'b1;
         pc_redirect_target = 32'd0;
      end else if (dstall) begin
         pc_load     = 1'b0;
         if_id_load  = 1'b0;
         id_ex_load  = 1'b0;
         ex_mem_load = 1'b0;
         mem_wb_load = 1'b0;
      end else if (lustall) begin
         pc_load      = 1'b0;
         if_id_load   = 1'b0;
         id_ex_bubble = 1'b1;
      end else if (state == KILL) begin
         // Whatever the I-cache returns here is wrong-path.
         if_id_bubble      = 1'b1;
         pc_load           = icache_resp;
         pc_redirect_valid = icache_resp;
      end else if (id_redirect && icache_resp) begin
         if_id_bubble      = 1'b1;
         pc_redirect_valid = 1'b1;
      end else if (!icache_resp) begin
         pc_load      = 1'b0;
         if_id_bubble = 1'b1;
      end
   end

endmodule
